micro_ondas_ctrl: RTL and testbench

- Microwave-oven controller: keypad time entry (M:ST), start/stop/clear control, door interlock, 1 Hz countdown, magnetron enable.
- Drives three 7-segment digits for minutes, seconds-tens and seconds-ones.
- Top-level control block; runs from a single slow system clock (nominal 100 Hz).

---
 rtl/micro_ondas_pkg.sv | 27 ++
 rtl/micro_ondas_seg7.sv | 29 ++
 rtl/micro_ondas_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_micro_ondas_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_ondas_pkg.sv
// micro_ondas_pkg
// Shared types and constants for the microwave-oven controller.
//   state_t      : controller state (IDLE / COOKING / PAUSED)
//   BCD_W        : width of one BCD time digit
//   TICK_W       : width of the one-second prescaler
//   SEG_TABLE    : active-high 7-segment patterns for digits 0..9 (bit0 = a .. bit6 = g)
//   SEG_BLANK    : pattern for non-decimal codes 10..15
package micro_ondas_pkg;

  localparam int BCD_W  = 4;
  localparam int TICK_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COOKING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  // Entry k holds the pattern for digit k (entry 0 is the least significant slice).
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/micro_ondas_seg7.sv
// micro_ondas_seg7
// Combinational BCD digit to 7-segment decoder.
//   i_digit [3:0] : BCD code; 10..15 show a blank digit
//   o_segs  [6:0] : segments, bit0 = a .. bit6 = g
// Build option SEG_ACTIVE_LOW_EN: when defined, o_segs is bitwise inverted
// for common-anode displays; otherwise segments are active-high.
module micro_ondas_seg7
  import micro_ondas_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  output logic [6:0]       o_segs
);

  logic [6:0] w_seg;

  always_comb begin
    w_seg = SEG_BLANK;
    for (int k = 0; k < 10; k++) begin
      if (i_digit == BCD_W'(k)) w_seg = SEG_TABLE[k];
    end
  end

`ifdef SEG_ACTIVE_LOW_EN
  assign o_segs = ~w_seg;
`else
  assign o_segs = w_seg;
`endif

endmodule

// File: rtl/micro_ondas_ctrl.sv
// micro_ondas_ctrl
// Microwave-oven controller: keypad M:ST time entry, start/stop/clear,
// door interlock, one-second countdown and magnetron enable.
// Ports:
//   clock          : system clock (nominally 100 Hz), rising edge
//   reset          : synchronous, active-high reset
//   keypad [9:0]   : one-hot digit keys, level while pressed
//   startn         : active-low start / resume
//   stopn          : active-low stop / pause
//   clearn         : active-low clear of entered time
//   door_closed    : 1 = door closed
//   sec_ones_segs  : seconds-ones display segments
//   sec_tens_segs  : seconds-tens display segments
//   mins_segs      : minutes display segments
//   mag_on         : magnetron enable (registered, high only while cooking)
// Parameter CLK_DIV (2..65535): clock cycles per countdown second.
// Build option SEG_ACTIVE_LOW_EN inverts all segment outputs (see micro_ondas_seg7).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting; digit entry allowed, start needs nonzero time
// COOKING | magnetron on, time counts down once per CLK_DIV cycles
// PAUSED  | stopped by stopn or open door; time and prescaler held
module micro_ondas_ctrl
  import micro_ondas_pkg::*;
#(
  parameter int CLK_DIV = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] keypad,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  output logic [6:0] sec_ones_segs,
  output logic [6:0] sec_tens_segs,
  output logic [6:0] mins_segs,
  output logic       mag_on
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);

  state_t              r_state;
  logic [BCD_W-1:0]    r_mins;
  logic [BCD_W-1:0]    r_tens;
  logic [BCD_W-1:0]    r_ones;
  logic [TICK_W-1:0]   r_tick;
  logic                r_key_prev;
  logic                r_mag;

  state_t              w_state_next;
  logic [BCD_W-1:0]    w_mins_next;
  logic [BCD_W-1:0]    w_tens_next;
  logic [BCD_W-1:0]    w_ones_next;
  logic [TICK_W-1:0]   w_tick_next;
  logic                w_mag_next;

  logic                w_key_valid;
  logic                w_key_edge;
  logic [BCD_W-1:0]    w_key_digit;
  logic                w_time_zero;
  logic                w_start;
  logic [BCD_W-1:0]    w_dec_mins;
  logic [BCD_W-1:0]    w_dec_tens;
  logic [BCD_W-1:0]    w_dec_ones;
  logic                w_dec_zero;

  // Keypad encoder: only a single pressed key counts; chords read as "no key".
  assign w_key_valid = $onehot(keypad);
  assign w_key_edge  = w_key_valid & ~r_key_prev;

  always_comb begin
    w_key_digit = '0;
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) w_key_digit = BCD_W'(i);
    end
  end

  assign w_time_zero = (r_mins == '0) && (r_tens == '0) && (r_ones == '0);
  // Door-closed is already implied by the priority chain below.
  assign w_start     = !startn && (r_state != ST_COOKING) && !w_time_zero;

  // One-second BCD decrement; tens above 5 (from entry) simply count down.
  always_comb begin
    w_dec_mins = r_mins;
    w_dec_tens = r_tens;
    w_dec_ones = r_ones;
    if (r_ones != '0) begin
      w_dec_ones = r_ones - 4'd1;
    end else if (r_tens != '0) begin
      w_dec_ones = 4'd9;
      w_dec_tens = r_tens - 4'd1;
    end else begin
      w_dec_ones = 4'd9;
      w_dec_tens = 4'd5;
      w_dec_mins = r_mins - 4'd1;
    end
  end

  assign w_dec_zero = (r_mins == '0) && (r_tens == '0) && (r_ones == 4'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_mins     <= '0;
      r_tens     <= '0;
      r_ones     <= '0;
      r_tick     <= '0;
      r_key_prev <= 1'b0;
      r_mag      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_mins     <= w_mins_next;
      r_tens     <= w_tens_next;
      r_ones     <= w_ones_next;
      r_tick     <= w_tick_next;
      r_key_prev <= w_key_valid;
      r_mag      <= w_mag_next;
    end
  end

  // Priority: clearn > (door open or stopn) > start > key entry > tick.
  always_comb begin
    w_state_next = r_state;
    w_mins_next  = r_mins;
    w_tens_next  = r_tens;
    w_ones_next  = r_ones;
    w_tick_next  = r_tick;
    w_mag_next   = r_mag;

    if (!clearn) begin
      w_state_next = ST_IDLE;
      w_mins_next  = '0;
      w_tens_next  = '0;
      w_ones_next  = '0;
      w_tick_next  = '0;
      w_mag_next   = 1'b0;
    end else if (!door_closed || !stopn) begin
      if (r_state == ST_COOKING) begin
        w_state_next = ST_PAUSED;
        w_mag_next   = 1'b0;
      end
    end else if (w_start) begin
      w_state_next = ST_COOKING;
      w_tick_next  = '0;
      w_mag_next   = 1'b1;
    end else if (w_key_edge && (r_state != ST_COOKING)) begin
      w_mins_next = r_tens;
      w_tens_next = r_ones;
      w_ones_next = w_key_digit;
    end else if (r_state == ST_COOKING) begin
      if (r_tick == TICK_LAST) begin
        w_tick_next = '0;
        w_mins_next = w_dec_mins;
        w_tens_next = w_dec_tens;
        w_ones_next = w_dec_ones;
        if (w_dec_zero) begin
          w_state_next = ST_IDLE;
          w_mag_next   = 1'b0;
        end
      end else begin
        w_tick_next = r_tick + 16'd1;
      end
    end
  end

  assign mag_on = r_mag;

  micro_ondas_seg7 u_seg_ones (
    .i_digit (r_ones),
    .o_segs  (sec_ones_segs)
  );

  micro_ondas_seg7 u_seg_tens (
    .i_digit (r_tens),
    .o_segs  (sec_tens_segs)
  );

  micro_ondas_seg7 u_seg_mins (
    .i_digit (r_mins),
    .o_segs  (mins_segs)
  );

endmodule

// File: tb/tb_micro_ondas_ctrl.sv
// tb_micro_ondas_ctrl
// Self-checking bench for micro_ondas_ctrl. A behavioural model keeps the
// time as minutes plus a seconds field (0..99) and steps it once per clock;
// the DUT outputs are compared against it every cycle. Directed scenarios add
// literal expectations, followed by a randomized stress phase.
module tb_micro_ondas_ctrl;

  localparam int CLK_DIV = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] keypad;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;
  logic [6:0] sec_ones_segs;
  logic [6:0] sec_tens_segs;
  logic [6:0] mins_segs;
  logic       mag_on;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: 0 idle, 1 cooking, 2 paused
  int m_mode = 0;
  int m_min  = 0;
  int m_sec  = 0;
  int m_tick = 0;
  int m_hist = 0;

  micro_ondas_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clock         (clock),
    .reset         (reset),
    .keypad        (keypad),
    .startn        (startn),
    .stopn         (stopn),
    .clearn        (clearn),
    .door_closed   (door_closed),
    .sec_ones_segs (sec_ones_segs),
    .sec_tens_segs (sec_tens_segs),
    .mins_segs     (mins_segs),
    .mag_on        (mag_on)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] pol(input logic [6:0] s);
`ifdef SEG_ACTIVE_LOW_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  function automatic logic [6:0] seg(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'h3F; 1: s = 7'h06; 2: s = 7'h5B; 3: s = 7'h4F; 4: s = 7'h66;
      5: s = 7'h6D; 6: s = 7'h7D; 7: s = 7'h07; 8: s = 7'h7F; 9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return pol(s);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int valid;
    int d;
    valid = ($countones(keypad) == 1) ? 1 : 0;
    d = 0;
    for (int i = 0; i < 10; i++) if (keypad[i]) d = i;
    if (reset) begin
      m_mode = 0; m_min = 0; m_sec = 0; m_tick = 0; m_hist = 0;
    end else begin
      if (!clearn) begin
        m_mode = 0; m_min = 0; m_sec = 0; m_tick = 0;
      end else if (!door_closed || !stopn) begin
        if (m_mode == 1) m_mode = 2;
      end else if (!startn && m_mode != 1 && (m_min != 0 || m_sec != 0)) begin
        m_mode = 1; m_tick = 0;
      end else if (valid == 1 && m_hist == 0 && m_mode != 1) begin
        m_min = m_sec / 10;
        m_sec = (m_sec % 10) * 10 + d;
      end else if (m_mode == 1) begin
        if (m_tick == CLK_DIV - 1) begin
          m_tick = 0;
          if (m_sec > 0) m_sec = m_sec - 1;
          else begin m_sec = 59; m_min = m_min - 1; end
          if (m_min == 0 && m_sec == 0) m_mode = 0;
        end else begin
          m_tick = m_tick + 1;
        end
      end
      m_hist = valid;
    end
  endtask

  // One clock: model advances with the DUT, then all outputs are compared.
  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    chk("ones_segs", sec_ones_segs, seg(m_sec % 10));
    chk("tens_segs", sec_tens_segs, seg(m_sec / 10));
    chk("mins_segs", mins_segs, seg(m_min));
    chk("mag_on", mag_on, (m_mode == 1) ? 1 : 0);
  endtask

  task automatic press(input int d, input int hold);
    keypad = 10'(1 << d);
    repeat (hold) cycle();
    keypad = '0;
    repeat (3) cycle();
  endtask

  task automatic pulse_start();
    startn = 1'b0;
    cycle();
    startn = 1'b1;
  endtask

  task automatic run_until(input int mn, input int sc, input int budget);
    int n;
    n = 0;
    while (!(m_min == mn && m_sec == sc) && n < budget) begin
      cycle();
      n++;
    end
    chk("time_reached", (m_min == mn && m_sec == sc) ? 1 : 0, 1);
  endtask

  task automatic lit_disp(input string name, input logic [6:0] mn,
                          input logic [6:0] tn, input logic [6:0] on);
    chk({name, "_mins"}, mins_segs, pol(mn));
    chk({name, "_tens"}, sec_tens_segs, pol(tn));
    chk({name, "_ones"}, sec_ones_segs, pol(on));
  endtask

  initial begin
    reset = 1'b1; keypad = '0; startn = 1'b1; stopn = 1'b1;
    clearn = 1'b1; door_closed = 1'b1;
    repeat (2) cycle();
    lit_disp("reset", 7'h3F, 7'h3F, 7'h3F);
    chk("reset_mag", mag_on, 0);
    reset = 1'b0;
    cycle();

    // entry 1, 0, 3 -> 1:03
    press(1, 10); press(0, 10); press(3, 10);
    lit_disp("entry", 7'h06, 7'h3F, 7'h4F);

    // cook from 1:03
    pulse_start();
    chk("start_mag", mag_on, 1);
    repeat (CLK_DIV) cycle();
    lit_disp("t102", 7'h06, 7'h3F, 7'h5B);
    repeat (3 * CLK_DIV) cycle();
    lit_disp("t059", 7'h3F, 7'h6D, 7'h6F);

    // pause at 0:45, door cycle, resume
    run_until(0, 45, 20 * CLK_DIV);
    stopn = 1'b0;
    cycle();
    stopn = 1'b1;
    chk("pause_mag", mag_on, 0);
    repeat (2 * CLK_DIV) cycle();
    lit_disp("paused", 7'h3F, 7'h66, 7'h6D);
    door_closed = 1'b0;
    repeat (3) cycle();
    door_closed = 1'b1;
    cycle();
    pulse_start();
    chk("resume_mag", mag_on, 1);
    lit_disp("resume", 7'h3F, 7'h66, 7'h6D);
    run_until(0, 0, 50 * CLK_DIV);
    chk("done_mag", mag_on, 0);
    lit_disp("done", 7'h3F, 7'h3F, 7'h3F);
    repeat (2) cycle();

    // interlock: 0:10 with door open, then start at 0:00
    press(1, 4); press(0, 4);
    lit_disp("e010", 7'h3F, 7'h06, 7'h3F);
    door_closed = 1'b0;
    pulse_start();
    chk("door_open_mag", mag_on, 0);
    repeat (2) cycle();
    door_closed = 1'b1;
    clearn = 1'b0;
    cycle();
    clearn = 1'b1;
    pulse_start();
    chk("zero_start_mag", mag_on, 0);

    // clear mid-cook
    press(2, 4); press(5, 4);
    pulse_start();
    repeat (2 * CLK_DIV + 2) cycle();
    clearn = 1'b0;
    cycle();
    clearn = 1'b1;
    lit_disp("clear", 7'h3F, 7'h3F, 7'h3F);
    chk("clear_mag", mag_on, 0);

    // reset coincident with a key edge
    press(4, 3);
    reset = 1'b1;
    keypad = 10'(1 << 7);
    cycle();
    lit_disp("rst_key", 7'h3F, 7'h3F, 7'h3F);
    reset = 1'b0;
    keypad = '0;
    cycle();
    chk("rst_key_ones", sec_ones_segs, pol(7'h3F));

    // randomized stress against the model
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 499) == 0);
      clearn      = !($urandom_range(0, 199) == 0);
      stopn       = !($urandom_range(0, 59) == 0);
      door_closed = !($urandom_range(0, 79) == 0);
      startn      = !($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0, 1: keypad = '0;
          2:    keypad = 10'(1 << $urandom_range(0, 9));
          default: keypad = 10'(1 << $urandom_range(0, 9)) | 10'(1 << $urandom_range(0, 9));
        endcase
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
